// File: rtl/spi_ram_if.sv
// Command/response bus between an SPI slave front end and spi_ram.
// The master drives 2-bit command + payload strobes; the slave returns read words and an error pulse.
interface spi_ram_if #(
    parameter int ADDR_SIZE = 8
);
    logic [ADDR_SIZE+1:0] rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 err;

    modport master (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid,
        input  err
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid,
        output err
    );
endinterface

// File: rtl/spi_ram.sv
// Small RAM addressed by SPI byte commands: separate write/read address registers,
// registered read data with a level-valid flag, and a one-cycle error pulse for rejected data commands.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    spi_ram_if.slave  bus
);
    localparam int                 IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE:0] DEPTH = MEM_DEPTH[ADDR_SIZE:0];

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    logic [ADDR_SIZE-1:0] r_mem [MEM_DEPTH];

    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_wr_addr_ok;
    logic                 r_rd_addr_ok;
    logic [ADDR_SIZE-1:0] r_tx_data;
    logic                 r_tx_valid;
    logic                 r_err;

    cmd_t                 w_cmd;
    logic [ADDR_SIZE-1:0] w_payload;
    logic                 w_wr_hit;
    logic                 w_rd_hit;
    logic                 w_wr_accept;

    assign w_cmd       = cmd_t'(bus.rx_data[ADDR_SIZE+1:ADDR_SIZE]);
    assign w_payload   = bus.rx_data[ADDR_SIZE-1:0];
    assign w_wr_hit    = r_wr_addr_ok && ({1'b0, r_wr_addr} < DEPTH);
    assign w_rd_hit    = r_rd_addr_ok && ({1'b0, r_rd_addr} < DEPTH);
    assign w_wr_accept = bus.rx_valid && (w_cmd == CMD_WR_DATA) && w_wr_hit;

    // Storage has no reset so contents survive rst; r_wr_addr_ok is cleared by rst, which blocks writes.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_addr[IDX_W-1:0]] <= w_payload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_wr_addr_ok <= 1'b0;
            r_rd_addr_ok <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (bus.rx_valid) begin
                // Every strobe re-decides tx_valid; only an accepted read keeps it high.
                r_tx_valid <= 1'b0;
                case (w_cmd)
                    CMD_WR_ADDR: begin
                        r_wr_addr    <= w_payload;
                        r_wr_addr_ok <= 1'b1;
                    end
                    CMD_WR_DATA: begin
                        if (w_wr_hit) begin
                            if (AUTO_INC) begin
                                r_wr_addr <= r_wr_addr + 1'b1;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    CMD_RD_ADDR: begin
                        r_rd_addr    <= w_payload;
                        r_rd_addr_ok <= 1'b1;
                    end
                    CMD_RD_DATA: begin
                        if (w_rd_hit) begin
                            r_tx_data  <= r_mem[r_rd_addr[IDX_W-1:0]];
                            r_tx_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_err <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.err      = r_err;
endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 8-bit words (1..256).
REQ-002 SHALL have parameter ADDR_SIZE, default 8, address and data width in bits.
REQ-003 SHALL have parameter AUTO_INC, default 0; when 1, the write address post-increments after each write.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port rx_data, input, ADDR_SIZE+2, with [9:8] the command and [7:0] the payload.
REQ-007 SHALL have port rx_valid, input, 1, a one-cycle strobe qualifying rx_data from the SPI slave interface.
REQ-008 SHALL have port tx_data, output, ADDR_SIZE, the read word presented to the SPI slave interface.
REQ-009 SHALL have port tx_valid, output, 1, which qualifies tx_data as a level.
REQ-010 SHALL have port err, output, 1, a one-cycle pulse for a rejected command.

Function
REQ-011 SHALL sample rx_data only on clock edges where rx_valid=1 and ignore it otherwise.
REQ-012 SHALL decode cmd 00 as write address: wr_addr<=payload, wr_addr_ok<=1.
REQ-013 SHALL decode cmd 01 as write data: mem[wr_addr]<=payload, only if wr_addr_ok=1 and wr_addr<MEM_DEPTH.
REQ-014 SHALL decode cmd 10 as read address: rd_addr<=payload, rd_addr_ok<=1.
REQ-015 SHALL decode cmd 11 as read data: tx_data<=mem[rd_addr] and tx_valid<=1 on the same edge, only if rd_addr_ok=1 and rd_addr<MEM_DEPTH.
REQ-016 SHALL provide tx_valid exactly 1 cycle after the rx_valid cycle, with registered read and no combinational path from rx_* to tx_*.
REQ-017 SHALL hold tx_valid=1 and a stable tx_data until the next rx_valid edge of any command.
REQ-018 SHALL recompute tx_valid on every rx_valid edge: tx_valid=1 only for an accepted cmd 11, else 0.
REQ-019 SHALL refresh tx_data and keep tx_valid=1 when back-to-back accepted cmd 11 arrive, including for a changed rd_addr.
REQ-020 SHALL make a cmd 01 with wr_addr_ok=0 or wr_addr>=MEM_DEPTH a no-op: memory unchanged, err=1 for 1 cycle.
REQ-021 SHALL make a cmd 11 with rd_addr_ok=0 or rd_addr>=MEM_DEPTH produce err=1 for 1 cycle, tx_valid=0, tx_data unchanged.
REQ-022 SHALL accept an address command with payload>=MEM_DEPTH; the error is flagged at the subsequent data command.
REQ-023 SHALL, with AUTO_INC=1, make wr_addr<=wr_addr+1 after each accepted write, wrapping 255->0 at ADDR_SIZE width.
REQ-024 SHALL make writes past MEM_DEPTH-1 then fall under REQ-020.
REQ-025 SHALL, with AUTO_INC=0, hold wr_addr constant across writes.
REQ-026 SHALL make rd_addr and wr_addr independent: reads never alter wr_addr, writes never alter rd_addr.
REQ-027 SHALL return the data just written when a write and a following read hit the same address on consecutive rx_valid edges.
REQ-028 SHALL keep err=0 whenever rx_valid=0.

Reset
REQ-029 SHALL, on rst=1 and regardless of clk, immediately force tx_valid=0, tx_data=0 and err=0.
REQ-030 SHALL, on rst=1, clear wr_addr=0, rd_addr=0, wr_addr_ok=0 and rd_addr_ok=0.
REQ-031 SHALL not clear memory contents on reset; they are retained.
REQ-032 SHALL let a reset during tx_valid=1 drop tx_valid asynchronously; afterwards cmd 11 errors until a new cmd 10.
REQ-033 SHALL ignore rx_valid while rst=1; the first edge after deassertion decodes normally.

Verification
REQ-034 SHALL cover: rx 0x012, then 0x1A5, then 0x212, then 0x300 -> tx_valid=1 with tx_data=0xA5 one cycle after the 4th strobe.
REQ-035 SHALL cover: after reset, rx 0x3xx -> err pulse 1 cycle, tx_valid=0; then rx 0x1xx -> err pulse, memory unchanged.
REQ-036 SHALL cover: MEM_DEPTH=16, rx 0x020, then 0x155 -> err=1, no write; rx 0x220, then 0x300 -> err=1, tx_valid=0.
REQ-037 SHALL cover: AUTO_INC=1, rx 0x0FF, 0x111, 0x122; read addresses 0xFF and 0x00 -> 0x11 and 0x22 respectively (wrap).
REQ-038 SHALL cover: tx_valid=1 holding 0xA5, then rx 0x0xx -> tx_valid=0 next cycle; back-to-back 0x3xx reads -> tx_valid stays 1, tx_data updates.
REQ-039 SHALL cover: assert rst mid-cycle while tx_valid=1 -> tx_valid=0 before the next edge; a prior write is still readable after a new cmd 10.
